// File: rtl/ag_burst_arbiter.sv
// Round-robin, non-preemptive burst scheduler sharing an address space split into two banks.
// Each grant emits a run of sequential {bank, offset} addresses, then a one-cycle done pulse.
module ag_burst_arbiter #(
    parameter int CNT_W = 7,
    parameter int LEN_W = 8
) (
    input  logic             m_clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [CNT_W-1:0] start0,
    input  logic [LEN_W-1:0] len0,
    input  logic             req1,
    input  logic [CNT_W-1:0] start1,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [CNT_W:0]   addr_out,
    output logic             addr_valid,
    output logic             done0,
    output logic             done1,
    output logic             busy
);

    localparam int REM_W = CNT_W + 1;
    localparam int CMP_W = (LEN_W > REM_W) ? LEN_W : REM_W;
    localparam logic [REM_W-1:0] BANK_SIZE = {1'b1, {CNT_W{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        GAP
    } state_t;

    state_t             state;
    logic               last;
    logic               cur_id;
    logic [CNT_W-1:0]   offset;
    logic [REM_W-1:0]   rem;

    logic               any_req;
    logic               sel_id;
    logic [CNT_W-1:0]   sel_start;
    logic [CMP_W-1:0]   sel_len;
    logic [REM_W-1:0]   sel_rem;
    logic [CNT_W-1:0]   next_offset;

    // Winner selection and length clamp for the grant edge.
    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        any_req     = req0 | req1;
        sel_id      = (req0 && req1) ? ~last : req1;
        sel_start   = sel_id ? start1 : start0;
        sel_len     = sel_id ? CMP_W'(len1) : CMP_W'(len0);
        sel_rem     = BANK_SIZE;
        if (sel_len <= CMP_W'(BANK_SIZE)) begin
            sel_rem = REM_W'(sel_len);
        end
        next_offset = offset + 1'b1;
    end

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            state      <= IDLE;
            last       <= 1'b1;
            cur_id     <= 1'b0;
            offset     <= '0;
            rem        <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            addr_out   <= '0;
            addr_valid <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        busy   <= 1'b1;
                        last   <= sel_id;
                        cur_id <= sel_id;
                        offset <= sel_start;
                        rem    <= sel_rem;
                        if (sel_rem == '0) begin
                            // Zero-length request: acknowledge immediately without addresses.
                            done0 <= ~sel_id;
                            done1 <= sel_id;
                            state <= GAP;
                        end else begin
                            addr_out   <= {sel_id, sel_start};
                            addr_valid <= 1'b1;
                            gnt0       <= ~sel_id;
                            gnt1       <= sel_id;
                            state      <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (rem > REM_W'(1)) begin
                        // Offset wraps inside the bank; the bank bit comes from cur_id only.
                        offset   <= next_offset;
                        rem      <= rem - 1'b1;
                        addr_out <= {cur_id, next_offset};
                    end else begin
                        addr_valid <= 1'b0;
                        gnt0       <= 1'b0;
                        gnt1       <= 1'b0;
                        done0      <= ~cur_id;
                        done1      <= cur_id;
                        state      <= GAP;
                    end
                end
                GAP: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ag_burst_arbiter.sv
// Scoreboard bench for ag_burst_arbiter: the driver predicts every address/done event into a
// queue from the arbitration rules, and a negedge monitor pops and compares what the DUT emits.
module tb_ag_burst_arbiter;

    logic       m_clk;
    logic       reset;
    logic       req0, req1;
    logic [6:0] start0, start1;
    logic [7:0] len0, len1;
    logic       gnt0, gnt1;
    logic [7:0] addr_out;
    logic       addr_valid;
    logic       done0, done1;
    logic       busy;

    ag_burst_arbiter #(.CNT_W(7), .LEN_W(8)) dut (
        .m_clk      (m_clk),
        .reset      (reset),
        .req0       (req0),
        .start0     (start0),
        .len0       (len0),
        .req1       (req1),
        .start1     (start1),
        .len1       (len1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .done0      (done0),
        .done1      (done1),
        .busy       (busy)
    );

    initial begin
        m_clk = 1'b0;
        forever #5 m_clk = ~m_clk;
    end

    typedef struct {
        bit         is_done;
        bit         id;
        logic [7:0] addr;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  last_m = 1'b1;
    bit  aborted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst is min(len,128) addresses walking the owner's bank, then done.
    task automatic push_burst(input bit id, input int s, input int l);
        ev_t e;
        int  n;
        n = (l > 128) ? 128 : l;
        for (int k = 0; k < n; k++) begin
            e.is_done = 1'b0;
            e.id      = id;
            e.addr    = 8'((int'(id) * 128) + ((s + k) % 128));
            exp_q.push_back(e);
        end
        e.is_done = 1'b1;
        e.id      = id;
        e.addr    = '0;
        exp_q.push_back(e);
    endtask

    // Monitor: consumes one expected event per cycle that shows addr_valid or a done pulse.
    bit prev_valid = 1'b0;
    always @(negedge m_clk) begin
        ev_t e;
        check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
        check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
        check("busy", {31'd0, busy}, {31'd0, gnt0 | gnt1 | done0 | done1});
        if (prev_valid && !addr_valid && !done0 && !done1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL burst_gap: got idle cycle required address or done at %0t", $time);
        end
        if (addr_valid || done0 || done1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: got valid=%0b done0=%0b done1=%0b required nothing at %0t",
                         addr_valid, done0, done1, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", {31'd0, done0 | done1}, {31'd0, e.is_done});
                if (e.is_done) begin
                    check("done_id", {30'd0, done1, done0}, e.id ? 32'd2 : 32'd1);
                    check("gnt_at_done", {30'd0, gnt1, gnt0}, 32'd0);
                end else begin
                    check("addr_out", {24'd0, addr_out}, {24'd0, e.addr});
                    check("gnt_owner", {30'd0, gnt1, gnt0}, e.id ? 32'd2 : 32'd1);
                end
            end
        end
        prev_valid = addr_valid && !aborted;
    end

    // One arbitration round: raise the chosen requests together from idle and hold each until done.
    task automatic do_round(input bit r0, input bit r1, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [7:0] l0, input logic [7:0] l1);
        bit first;
        bit need[2];
        bit seen_act[2];
        bit seen_done[2];
        int done_cyc[2];
        int cyc;
        bit act_now;
        bit dn;
        need[0] = r0;
        need[1] = r1;
        seen_act  = '{1'b0, 1'b0};
        seen_done = '{1'b0, 1'b0};
        done_cyc  = '{0, 0};
        first = (r0 && r1) ? ~last_m : r1;
        if (first) push_burst(1'b1, int'(s1), int'(l1));
        else       push_burst(1'b0, int'(s0), int'(l0));
        last_m = first;
        if (r0 && r1) begin
            if (first) push_burst(1'b0, int'(s0), int'(l0));
            else       push_burst(1'b1, int'(s1), int'(l1));
            last_m = ~first;
        end
        req0 = r0; start0 = s0; len0 = l0;
        req1 = r1; start1 = s1; len1 = l1;
        cyc = 0;
        while (!((!need[0] || seen_done[0]) && (!need[1] || seen_done[1])) && cyc < 400) begin
            @(posedge m_clk);
            #2;
            cyc++;
            for (int id = 0; id < 2; id++) begin
                dn      = (id == 0) ? done0 : done1;
                act_now = (id == 0) ? (gnt0 | done0) : (gnt1 | done1);
                if (need[id] && act_now && !seen_act[id]) begin
                    seen_act[id] = 1'b1;
                    check("grant_latency", cyc, (id == int'(first)) ? 1 : done_cyc[int'(first)] + 2);
                    if (!dn) begin
                        // Inputs after grant must be ignored; sometimes drop req mid-burst too.
                        if (id == 0) begin
                            start0 = 7'($urandom); len0 = 8'($urandom);
                            if ($urandom_range(0, 1) == 1) req0 = 1'b0;
                        end else begin
                            start1 = 7'($urandom); len1 = 8'($urandom);
                            if ($urandom_range(0, 1) == 1) req1 = 1'b0;
                        end
                    end
                end
                if (need[id] && dn && !seen_done[id]) begin
                    seen_done[id] = 1'b1;
                    done_cyc[id]  = cyc;
                    if (id == 0) req0 = 1'b0;
                    else         req1 = 1'b0;
                end
            end
        end
        check("round_complete", {30'd0, seen_done[1], seen_done[0]}, {30'd0, need[1], need[0]});
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) begin
            @(posedge m_clk);
            #2;
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {18'd0, gnt0, gnt1, addr_out, addr_valid, done0, done1, busy}, 32'd0);
    endtask

    // Reset lands during the second address of a 10-long burst; the burst must vanish without done.
    task automatic reset_abort();
        int nv;
        int cyc;
        push_burst(1'b0, 20, 10);
        req0 = 1'b1; start0 = 7'd20; len0 = 8'd10;
        nv = 0;
        cyc = 0;
        while (nv < 2 && cyc < 50) begin
            @(posedge m_clk);
            #2;
            cyc++;
            if (addr_valid) nv++;
        end
        check("abort_reached", nv, 2);
        reset   = 1'b1;
        aborted = 1'b1;
        @(posedge m_clk);
        #2;
        check_all_zero("abort_outputs");
        reset   = 1'b0;
        aborted = 1'b0;
        req0    = 1'b0;
        exp_q.delete();
        last_m  = 1'b1;
        repeat (3) begin
            @(posedge m_clk);
            #2;
        end
    endtask

    initial begin
        bit [1:0]   mask;
        logic [7:0] la, lb;
        reset = 1'b1;
        req0 = 1'b0; start0 = '0; len0 = '0;
        req1 = 1'b0; start1 = '0; len1 = '0;
        repeat (3) begin
            @(posedge m_clk);
            #2;
        end
        check_all_zero("reset_state");
        reset = 1'b0;
        @(posedge m_clk);
        #2;

        do_round(1'b1, 1'b0, 7'd5, 7'd0, 8'd3, 8'd0);
        do_round(1'b0, 1'b1, 7'd0, 7'd126, 8'd0, 8'd4);
        do_round(1'b1, 1'b1, 7'd0, 7'd10, 8'd2, 8'd2);
        do_round(1'b1, 1'b1, 7'd0, 7'd10, 8'd2, 8'd2);
        do_round(1'b1, 1'b0, 7'd9, 7'd0, 8'd0, 8'd0);
        do_round(1'b1, 1'b1, 7'd3, 7'd4, 8'd0, 8'd5);
        do_round(1'b1, 1'b0, 7'd0, 7'd0, 8'd200, 8'd0);
        do_round(1'b0, 1'b1, 7'd100, 7'd127, 8'd1, 8'd128);
        reset_abort();
        do_round(1'b1, 1'b1, 7'd7, 7'd8, 8'd3, 8'd3);

        for (int r = 0; r < 40; r++) begin
            mask = 2'($urandom_range(1, 3));
            la = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            lb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            do_round(mask[0], mask[1], 7'($urandom), 7'($urandom), la, lb);
        end

        repeat (4) begin
            @(posedge m_clk);
            #2;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
